// File: rtl/ldst_control_sequencer.sv
// Step T3+ control sequencer for ld/ldi/st: drives datapath strobes and
// handshakes with memory, aborting when mem_ready stalls too long.
module ldst_control_sequencer #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       mem_ready,
    output logic       Grb,
    output logic       BAout,
    output logic       Yin,
    output logic       Cout,
    output logic       ADD,
    output logic       Zin,
    output logic       Zlowout,
    output logic       MARin,
    output logic       MDRin,
    output logic       MDRout,
    output logic       Read,
    output logic       Write,
    output logic       Gra,
    output logic       Rin,
    output logic       Rout,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // state | meaning
    // IDLE  | waiting for start
    // T3    | base register to Y (R0 reads as zero)
    // T4    | Z = Y + C
    // T5    | address to MAR (ld/st) or result to Ra (ldi)
    // T6    | ld: memory read wait; st: Ra to MDR
    // T7    | ld: MDR to Ra; st: memory write wait
    // ABORT | one-cycle error pulse
    typedef enum logic [2:0] {IDLE, T3, T4, T5, T6, T7, ABORT} state_t;

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_ST  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;
    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    state_t     state, state_nxt;
    logic [1:0] op_q;
    logic [7:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            op_q  <= 2'b00;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && start && op != OP_RSV)
                op_q <= op;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        Grb = 1'b0; BAout = 1'b0; Yin = 1'b0; Cout = 1'b0; ADD = 1'b0;
        Zin = 1'b0; Zlowout = 1'b0; MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
        Read = 1'b0; Write = 1'b0; Gra = 1'b0; Rin = 1'b0; Rout = 1'b0;
        done = 1'b0; err = 1'b0;
        busy = (state != IDLE);
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (op == OP_RSV) ? ABORT : T3;
            end
            T3: begin
                Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                state_nxt = T4;
            end
            T4: begin
                Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
                state_nxt = T5;
            end
            T5: begin
                Zlowout = 1'b1;
                if (op_q == OP_LDI) begin
                    Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    MARin = 1'b1;
                    cnt_nxt = 8'd0;
                    state_nxt = T6;
                end
            end
            T6: begin
                if (op_q == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    cnt_nxt = 8'd0;
                    state_nxt = T7;
                end else begin
                    Read = 1'b1;
                    MDRin = mem_ready;
                    if (mem_ready)
                        state_nxt = T7;
                    else if (cnt == WAIT_LIM)
                        state_nxt = ABORT;
                    else
                        cnt_nxt = cnt + 8'd1;
                end
            end
            T7: begin
                if (op_q == OP_ST) begin
                    Write = 1'b1;
                    // completion takes priority over the timeout in the same cycle
                    if (mem_ready) begin
                        done = 1'b1;
                        state_nxt = IDLE;
                    end else if (cnt == WAIT_LIM)
                        state_nxt = ABORT;
                    else
                        cnt_nxt = cnt + 8'd1;
                end else begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ABORT: begin
                err = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
